// File: rtl/de_pkg.sv
// Shared definitions for the drawing-engine memory responder:
// bus widths, FSM state encoding and byte-lane enable conversion.
package de_pkg;

    localparam int DE_ADDR_W = 18;
    localparam int DE_DATA_W = 32;
    localparam int DE_LANES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DE_RD,
        ST_VID_RD,
        ST_DE_DONE,
        ST_VID_DONE
    } de_state_t;

    // Initiator lane enables are active-low; the RAM wants active-high.
    function automatic logic [DE_LANES-1:0] nbyte_to_we(input logic [DE_LANES-1:0] nbyte);
        return ~nbyte;
    endfunction

endpackage

// File: rtl/de_arbiter.sv
// Video-first arbiter with a bounded-wait counter so a drawing-engine
// request cannot be starved by a continuous video stream.
module de_arbiter #(
    parameter int DE_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic de_req,
    input  logic vid_req,
    output logic grant_de,
    output logic grant_vid
);

    localparam logic [7:0] MAX_WAIT = 8'(DE_MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       de_forced;

    always_comb begin
        de_forced = (wait_cnt == MAX_WAIT);
        grant_de  = idle && de_req && (!vid_req || de_forced);
        grant_vid = idle && vid_req && !grant_de;
    end

    // Counts every cycle a DE request goes unserved, whatever the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (!de_req || grant_de) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != MAX_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/de_mem_responder.sv
// Responder for the de_req/de_ack memory interface: arbitrates drawing-engine
// and video requests onto a single-port frame-store RAM with byte enables.
module de_mem_responder
    import de_pkg::*;
#(
    parameter int DE_MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_req,
    output logic                 de_ack,
    input  logic [DE_ADDR_W-1:0] de_addr,
    input  logic [DE_LANES-1:0]  de_nbyte,
    input  logic                 de_rnw,
    input  logic [DE_DATA_W-1:0] de_w_data,
    output logic [DE_DATA_W-1:0] de_r_data,
    input  logic                 vid_req,
    input  logic [DE_ADDR_W-1:0] vid_addr,
    output logic                 vid_ack,
    output logic [DE_DATA_W-1:0] vid_data,
    output logic                 ram_en,
    output logic [DE_LANES-1:0]  ram_we,
    output logic [DE_ADDR_W-1:0] ram_addr,
    output logic [DE_DATA_W-1:0] ram_wdata,
    input  logic [DE_DATA_W-1:0] ram_rdata
);

    de_state_t state;
    de_state_t state_next;
    logic      idle;
    logic      grant_de;
    logic      grant_vid;

    // Gating with reset keeps the RAM quiet during the reset cycle itself.
    assign idle = (state == ST_IDLE) && !reset;

    de_arbiter #(
        .DE_MAX_WAIT(DE_MAX_WAIT)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle),
        .de_req   (de_req),
        .vid_req  (vid_req),
        .grant_de (grant_de),
        .grant_vid(grant_vid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_vid) begin
                    state_next = ST_VID_RD;
                end else if (grant_de) begin
                    state_next = de_rnw ? ST_DE_RD : ST_DE_DONE;
                end
            end
            ST_DE_RD:    state_next = ST_DE_DONE;
            ST_VID_RD:   state_next = ST_VID_DONE;
            ST_DE_DONE:  state_next = ST_IDLE;
            ST_VID_DONE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        de_ack    = (state == ST_DE_DONE);
        vid_ack   = (state == ST_VID_DONE);
        ram_en    = grant_de || grant_vid;
        ram_we    = '0;
        ram_addr  = grant_vid ? vid_addr : de_addr;
        ram_wdata = de_w_data;
        if (grant_de && !de_rnw) begin
            ram_we = nbyte_to_we(de_nbyte);
        end
    end

    // Read data arrives the cycle after the access and is held until replaced.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_r_data <= '0;
            vid_data  <= '0;
        end else begin
            if (state == ST_DE_RD) begin
                de_r_data <= ram_rdata;
            end
            if (state == ST_VID_RD) begin
                vid_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_de_mem_responder.sv
// Scoreboard bench for de_mem_responder with a behavioural byte-lane RAM.
module tb_de_mem_responder;

    typedef struct {
        logic        rnw;
        logic [31:0] data;
    } de_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        de_req = 1'b0;
    logic        de_ack;
    logic [17:0] de_addr = '0;
    logic [3:0]  de_nbyte = 4'hF;
    logic        de_rnw = 1'b1;
    logic [31:0] de_w_data = '0;
    logic [31:0] de_r_data;
    logic        vid_req = 1'b0;
    logic [17:0] vid_addr = '0;
    logic        vid_ack;
    logic [31:0] vid_data;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [17:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int checks = 0;
    int failures = 0;
    int de_ack_cnt = 0;
    int vid_ack_cnt = 0;

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];
    de_exp_t     de_q[$];
    logic [31:0] vid_q[$];

    de_mem_responder #(
        .DE_MAX_WAIT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .de_req   (de_req),
        .de_ack   (de_ack),
        .de_addr  (de_addr),
        .de_nbyte (de_nbyte),
        .de_rnw   (de_rnw),
        .de_w_data(de_w_data),
        .de_r_data(de_r_data),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_data (vid_data),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            for (int l = 0; l < 4; l++) begin
                if (ram_we[l]) mem[ram_addr[9:0]][8*l +: 8] <= ram_wdata[8*l +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr[9:0]];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Ack-side of the scoreboard: every ack consumes one expectation.
    always @(negedge clk) begin
        if (!reset && de_ack) begin
            de_ack_cnt++;
            if (de_q.size() == 0) begin
                check_output("de_spurious_ack", 32'(de_ack), 32'd0);
            end else begin
                de_exp_t e;
                e = de_q.pop_front();
                if (e.rnw) check_output("de_rdata", de_r_data, e.data);
            end
        end
        if (!reset && vid_ack) begin
            vid_ack_cnt++;
            if (vid_q.size() == 0) check_output("vid_spurious_ack", 32'(vid_ack), 32'd0);
            else check_output("vid_data", vid_data, vid_q.pop_front());
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] nbyte);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (!nbyte[l]) r[8*l +: 8] = nw[8*l +: 8];
        return r;
    endfunction

    task automatic apply_stimulus(input logic rnw, input logic [17:0] addr, input logic [3:0] nbyte,
                                  input logic [31:0] data, input logic [3:0] exp_we, input int exp_lat);
        de_exp_t e;
        int cyc;
        logic got;
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = rnw; de_addr = addr; de_nbyte = nbyte; de_w_data = data;
        e.rnw = rnw;
        e.data = shadow[addr[9:0]];
        if (!rnw) shadow[addr[9:0]] = merge(shadow[addr[9:0]], data, nbyte);
        de_q.push_back(e);
        cyc = 0;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_output("grant_en", 32'(ram_en), 32'd1);
                check_output("grant_we", 32'(ram_we), 32'(exp_we));
                check_output("grant_addr", 32'(ram_addr), 32'(addr));
                if (!rnw && exp_we != 4'b0000) check_output("grant_wdata", ram_wdata, data);
            end
            if (de_ack) got = 1'b1;
        end
        check_output("de_ack_seen", 32'(got), 32'd1);
        if (got) check_output("de_latency", 32'(cyc), 32'(exp_lat));
        @(posedge clk); #1;
        de_req = 1'b0;
    endtask

    initial begin
        int cyc, de_at, vid_at, vids_before, d0, v0;
        logic stop, drop_vid;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_de_ack", 32'(de_ack), 32'd0);
        check_output("rst_vid_ack", 32'(vid_ack), 32'd0);
        check_output("rst_ram_en", 32'(ram_en), 32'd0);
        check_output("rst_ram_we", 32'(ram_we), 32'd0);
        check_output("rst_de_r_data", de_r_data, 32'd0);
        check_output("rst_vid_data", vid_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full write, readback, partial write, masked-off write.
        apply_stimulus(1'b0, 18'h00010, 4'b0000, 32'hDEADBEEF, 4'b1111, 2);
        apply_stimulus(1'b1, 18'h00010, 4'b0000, 32'h0, 4'b0000, 3);
        apply_stimulus(1'b0, 18'h00010, 4'b1010, 32'h11223344, 4'b0101, 2);
        apply_stimulus(1'b1, 18'h00010, 4'b0000, 32'h0, 4'b0000, 3);
        check_output("partial_value", de_r_data, 32'hDE22BE44);
        apply_stimulus(1'b0, 18'h00010, 4'b1111, 32'hFFFFFFFF, 4'b0000, 2);
        apply_stimulus(1'b1, 18'h00010, 4'b0000, 32'h0, 4'b0000, 3);
        apply_stimulus(1'b0, 18'h00020, 4'b0000, 32'hCAFEF00D, 4'b1111, 2);

        // Simultaneous requests: video first, then DE, each acked once.
        d0 = de_ack_cnt; v0 = vid_ack_cnt;
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00010; de_nbyte = 4'b0000;
        vid_req = 1'b1; vid_addr = 18'h00020;
        de_q.push_back('{1'b1, shadow[10'h010]});
        vid_q.push_back(shadow[10'h020]);
        cyc = 0; de_at = 0; vid_at = 0;
        while (cyc < 20 && (de_at == 0 || vid_at == 0)) begin
            @(negedge clk);
            cyc++;
            if (de_ack && de_at == 0) de_at = cyc;
            if (vid_ack && vid_at == 0) vid_at = cyc;
            @(posedge clk); #1;
            if (de_at != 0) de_req = 1'b0;
            if (vid_at != 0) vid_req = 1'b0;
        end
        de_req = 1'b0; vid_req = 1'b0;
        check_output("sim_vid_at", 32'(vid_at), 32'd3);
        check_output("sim_de_at", 32'(de_at), 32'd6);
        repeat (6) @(posedge clk);
        check_output("sim_de_count", 32'(de_ack_cnt - d0), 32'd1);
        check_output("sim_vid_count", 32'(vid_ack_cnt - v0), 32'd1);

        // Continuous video: DE forced through once the wait counter saturates.
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00010;
        vid_req = 1'b1; vid_addr = 18'h00020;
        de_q.push_back('{1'b1, shadow[10'h010]});
        vid_q.push_back(shadow[10'h020]);
        cyc = 0; de_at = 0; vids_before = 0; stop = 1'b0; drop_vid = 1'b0;
        while (cyc < 40 && !stop) begin
            @(negedge clk); #2;
            cyc++;
            if (vid_ack) begin
                if (de_at == 0) begin
                    vids_before++;
                    vid_q.push_back(shadow[10'h020]);
                end else begin
                    drop_vid = 1'b1;
                end
            end
            if (de_ack && de_at == 0) de_at = cyc;
            @(posedge clk); #1;
            if (de_at != 0) de_req = 1'b0;
            if (drop_vid) begin
                vid_req = 1'b0;
                stop = 1'b1;
            end
        end
        de_req = 1'b0; vid_req = 1'b0;
        check_output("starve_de_at", 32'(de_at), 32'd12);
        check_output("starve_vids_before", 32'(vids_before), 32'd3);
        check_output("starve_drained", 32'(stop), 32'd1);
        repeat (4) @(posedge clk);

        // Reset while a DE read is waiting for data.
        @(posedge clk); #1;
        de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'h00020;
        de_q.push_back('{1'b1, shadow[10'h020]});
        @(negedge clk);
        check_output("rstx_grant", 32'(ram_en), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("rstx_ack_in_reset", 32'(de_ack), 32'd0);
        check_output("rstx_en_in_reset", 32'(ram_en), 32'd0);
        check_output("rstx_we_in_reset", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("rstx_no_ack", 32'(de_ack), 32'd0);
        check_output("rstx_rdata_cleared", de_r_data, 32'd0);
        check_output("rstx_regrant", 32'(ram_en), 32'd1);
        check_output("rstx_regrant_addr", 32'(ram_addr), 32'h00020);
        cyc = 0;
        while (cyc < 20 && !de_ack) begin
            @(negedge clk);
            cyc++;
        end
        check_output("rstx_latency", 32'(cyc), 32'd2);
        @(posedge clk); #1;
        de_req = 1'b0;
        repeat (4) @(posedge clk);
        check_output("queues_drained", 32'(de_q.size() + vid_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
